// File: rtl/core_pkg.sv
// Shared Mini-core definitions: datapath width, op and state encodings,
// and bit positions inside the {Z, N, C, V} flag word.
package core_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FLAGS_W = 4;

  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/ADD_SUB.sv
// ADD_SUB: combinational adder/subtractor, result truncated to WIDTH bits.
// Ports: in1, in2 operands; add_or_sub 0 = add, 1 = subtract; out result.
module ADD_SUB #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             add_or_sub,
  output logic [WIDTH-1:0] out
);

  assign out = add_or_sub ? (in1 - in2) : (in1 + in2);

endmodule

// File: rtl/acc_stage.sv
// acc_stage: 8-bit accumulator behind ADD_SUB with request/response
// valid/ready handshakes. One operation occupies IDLE, EXEC, RESP.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake carrying op and operand
//   op, operand         00 LOAD, 01 ADD, 10 SUB, 11 CLR; second operand
//   out_valid/out_ready response handshake
//   acc, flags          accumulator and {Z, N, C, V}
module acc_stage
  import core_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   acc,
  output logic [FLAGS_W-1:0] flags
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [FLAGS_W-1:0] flags_q, flags_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   as_out;
  logic [WIDTH-1:0]   res;
  logic [FLAGS_W-1:0] res_flags;

  ADD_SUB #(.WIDTH(WIDTH)) u_add_sub (
    .in1        (acc_q),
    .in2        (opnd_q),
    .add_or_sub (op_q == OP_SUB),
    .out        (as_out)
  );

  // Result and flags for the captured op; C/V derived here since ADD_SUB
  // only returns the truncated sum. Add carries out iff the sum wrapped
  // below the old accumulator.
  always_comb begin
    res       = '0;
    res_flags = '0;
    case (op_q)
      OP_LOAD: res = opnd_q;
      OP_ADD: begin
        res              = as_out;
        res_flags[FLG_C] = (as_out < acc_q);
        res_flags[FLG_V] = (acc_q[WIDTH-1] == opnd_q[WIDTH-1]) &&
                           (as_out[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OP_SUB: begin
        res              = as_out;
        res_flags[FLG_C] = (acc_q < opnd_q);
        res_flags[FLG_V] = (acc_q[WIDTH-1] != opnd_q[WIDTH-1]) &&
                           (as_out[WIDTH-1] != acc_q[WIDTH-1]);
      end
      default: res = '0;
    endcase
    res_flags[FLG_Z] = (res == '0);
    res_flags[FLG_N] = res[WIDTH-1];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_EXEC;
          op_d    = op_e'(op);
          opnd_d  = operand;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
        acc_d   = res;
        flags_d = res_flags;
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_RESP);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LOAD;
      opnd_q      <= '0;
      acc_q       <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign acc       = acc_q;
  assign flags     = flags_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_acc_stage.sv
// Scoreboard bench for acc_stage: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every response handshake.
module tb_acc_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [7:0] operand;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] acc;
  logic [3:0] flags;

  localparam logic [1:0] LD = 2'b00, AD = 2'b01, SB = 2'b10, CL = 2'b11;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [11:0] exp_q[$];
  int pop_cyc[$];

  acc_stage #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand(operand), .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_response: acc=%h flags=%b", acc, flags);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({acc, flags} !== e) begin
          miscompares++;
          $display("FAIL response: acc=%h flags=%b, expected acc=%h flags=%b",
                   acc, flags, e[11:4], e[3:0]);
        end
      end
      pop_cyc.push_back(cyc);
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [7:0] d,
                       input logic [7:0] ea, input logic [3:0] ef);
    int n;
    exp_q.push_back({ea, ef});
    in_valid = 1'b1;
    op = o;
    operand = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  initial begin
    logic [7:0] h_acc;
    logic [3:0] h_flags;
    int n;
    int rise_cyc;
    rst = 1'b1; in_valid = 1'b0; op = LD; operand = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_acc", 32'(acc), 32'h00);
    check("reset_flags", 32'(flags), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Arithmetic cases, with acceptance-to-update latency checked once.
    issue(LD, 8'h11, 8'h11, 4'b0000);
    issue(AD, 8'h01, 8'h12, 4'b0000);
    @(negedge clk);
    check("exec_no_valid", 32'(out_valid), 32'd0);
    check("exec_acc_old", 32'(acc), 32'h11);
    @(negedge clk);
    check("resp_valid", 32'(out_valid), 32'd1);
    check("resp_acc_new", 32'(acc), 32'h12);
    @(posedge clk); #1;
    issue(LD, 8'h37, 8'h37, 4'b0000);
    issue(AD, 8'h81, 8'hB8, 4'b0100);
    issue(LD, 8'hF5, 8'hF5, 4'b0100);
    issue(SB, 8'hE2, 8'h13, 4'b0000);
    issue(LD, 8'hFF, 8'hFF, 4'b0100);
    issue(SB, 8'h5A, 8'hA5, 4'b0100);
    issue(LD, 8'h7F, 8'h7F, 4'b0000);
    issue(AD, 8'h01, 8'h80, 4'b0101);
    issue(LD, 8'hFF, 8'hFF, 4'b0100);
    issue(AD, 8'h01, 8'h00, 4'b1010);
    issue(LD, 8'h00, 8'h00, 4'b1000);
    issue(SB, 8'h01, 8'hFF, 4'b0110);
    issue(CL, 8'h5C, 8'h00, 4'b1000);
    drain();

    // Throughput with in_valid and out_ready held high.
    pop_cyc.delete();
    issue(LD, 8'h01, 8'h01, 4'b0000);
    issue(AD, 8'h01, 8'h02, 4'b0000);
    issue(AD, 8'h01, 8'h03, 4'b0000);
    drain();
    check("tput_pops", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("tput_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd3);
      check("tput_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd3);
    end

    // Backpressure: hold out_ready low for 5 cycles with a pending request.
    out_ready = 1'b0;
    issue(AD, 8'h10, 8'h13, 4'b0000);
    in_valid = 1'b1; op = SB; operand = 8'h03;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    check("bp_valid_rise", 32'(out_valid), 32'd1);
    h_acc = acc; h_flags = flags;
    check("bp_acc", 32'(h_acc), 32'h13);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_acc", 32'(acc), 32'(h_acc));
      check("bp_hold_flags", 32'(flags), 32'(h_flags));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    rise_cyc = cyc;
    issue(SB, 8'h03, 8'h10, 4'b0000);
    check("bp_accept_edge", 32'(acc_cyc - rise_cyc), 32'd2);
    drain();

    // Reset during EXEC.
    issue(LD, 8'h44, 8'h44, 4'b0000);
    void'(exp_q.pop_back());
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_exec_acc", 32'(acc), 32'h00);
    check("rst_exec_flags", 32'(flags), 32'h0);
    check("rst_exec_valid", 32'(out_valid), 32'd0);
    check("rst_exec_ready", 32'(in_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("rst_exec_no_resp", 32'(out_valid), 32'd0);
    check("rst_exec_acc_kept", 32'(acc), 32'h00);
    @(posedge clk); #1;

    // Reset during RESP.
    out_ready = 1'b0;
    issue(LD, 8'h99, 8'h99, 4'b0100);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    check("rst_resp_in_resp", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_resp_acc", 32'(acc), 32'h00);
    check("rst_resp_flags", 32'(flags), 32'h0);
    check("rst_resp_valid", 32'(out_valid), 32'd0);
    check("rst_resp_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Post-reset sanity.
    issue(AD, 8'h05, 8'h05, 4'b0000);
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
